// File: rtl/lsu_misaligned_seq.sv
`default_nettype none
// ============================================================================
// lsu_misaligned_seq : splits one LSU access into one or two aligned bus beats
// Rev 1.0
// ============================================================================
module lsu_misaligned_seq #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_type_i,
    input  logic              lsu_sign_ext_i,
    input  logic [31:0]       lsu_wdata_i,
    input  logic [ADDR_W-1:0] adder_result_ex_i,
    output logic              lsu_addr_incr_req_o,
    output logic [ADDR_W-1:0] lsu_addr_last_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic              data_err_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [31:0]       data_wdata_o,
    input  logic [31:0]       data_rdata_i,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_resp_valid_o,
    output logic              load_err_o,
    output logic              store_err_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        WAIT_GNT_MIS    = 3'd1,
        WAIT_RVALID_MIS = 3'd2,
        WAIT_GNT        = 3'd3,
        WAIT_RVALID     = 3'd4
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_last_q;
    logic [31:0]       rdata_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              split_q;
    logic [1:0]        type_q;
    logic              we_q;
    logic              sign_q;
    logic [1:0]        off_q;

    logic        w_idle;
    logic        w_second;
    logic        w_split_new;
    logic [1:0]  w_type;
    logic [1:0]  w_off;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [4:0]  w_sh;
    logic [31:0] w_rot;
    logic [3:0]  w_be;
    logic [31:0] w_lo;
    logic [31:0] w_comb;
    logic [31:0] w_ext;
    logic        w_err;

    function automatic logic [3:0] be_calc(input logic [1:0] typ, input logic [1:0] off,
                                           input logic second);
        logic [3:0] be;
        case (typ)
            2'b01:   be = (off == 2'd3) ? (second ? 4'b0001 : 4'b1000) : (4'b0011 << off);
            2'b10:   be = 4'b0001 << off;
            default: be = second ? (4'b1111 >> (3'd4 - {1'b0, off})) : (4'b1111 << off);
        endcase
        return be;
    endfunction

    // In IDLE the request is driven straight from EX; afterwards from the captured copy.
    assign w_idle  = (state_q == IDLE);
    assign w_type  = w_idle ? lsu_type_i : type_q;
    assign w_off   = w_idle ? adder_result_ex_i[1:0] : off_q;
    assign w_we    = w_idle ? lsu_we_i : we_q;
    assign w_wdata = w_idle ? lsu_wdata_i : wdata_q;

    assign w_split_new = ((lsu_type_i == 2'b00 || lsu_type_i == 2'b11) && adder_result_ex_i[1:0] != 2'd0)
                       || (lsu_type_i == 2'b01 && adder_result_ex_i[1:0] == 2'd3);

    assign w_second = (state_q == WAIT_RVALID_MIS) || (state_q == WAIT_GNT && split_q);
    assign w_sh     = {w_off, 3'b000};
    assign w_rot    = (w_wdata << w_sh) | (w_wdata >> (6'd32 - {1'b0, w_sh}));
    assign w_be     = be_calc(w_type, w_off, w_second);

    always_comb begin
        data_req_o = 1'b0;
        case (state_q)
            IDLE:                   data_req_o = lsu_req_i;
            WAIT_GNT_MIS, WAIT_GNT: data_req_o = 1'b1;
            WAIT_RVALID_MIS:        data_req_o = data_rvalid_i;
            default:                data_req_o = 1'b0;
        endcase
    end

    assign data_addr_o  = data_req_o ? {adder_result_ex_i[ADDR_W-1:2], 2'b00} : '0;
    assign data_be_o    = data_req_o ? w_be : 4'b0000;
    assign data_wdata_o = data_req_o ? w_rot : 32'd0;
    assign data_we_o    = data_req_o & w_we;

    assign lsu_addr_incr_req_o = w_second;
    assign lsu_addr_last_o     = addr_last_q;
    assign busy_o              = !w_idle;

    // Two-word window shifted down by the byte offset merges both beats of a split load.
    assign w_lo   = split_q ? rdata_q : data_rdata_i;
    assign w_comb = 32'({data_rdata_i, w_lo} >> {off_q, 3'b000});

    always_comb begin
        w_ext = w_comb;
        case (type_q)
            2'b10:   w_ext = {{24{sign_q & w_comb[7]}}, w_comb[7:0]};
            2'b01:   w_ext = {{16{sign_q & w_comb[15]}}, w_comb[15:0]};
            default: w_ext = w_comb;
        endcase
    end

    assign lsu_resp_valid_o = (state_q == WAIT_RVALID) && data_rvalid_i;
    assign w_err            = err_q | data_err_i;
    assign load_err_o       = lsu_resp_valid_o & w_err & !we_q;
    assign store_err_o      = lsu_resp_valid_o & w_err & we_q;
    assign lsu_rdata_o      = (lsu_resp_valid_o && !we_q) ? w_ext : 32'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_last_q <= '0;
            rdata_q     <= 32'd0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
            type_q      <= 2'b00;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            off_q       <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        addr_last_q <= adder_result_ex_i;
                        type_q      <= lsu_type_i;
                        we_q        <= lsu_we_i;
                        sign_q      <= lsu_sign_ext_i;
                        off_q       <= adder_result_ex_i[1:0];
                        wdata_q     <= lsu_wdata_i;
                        split_q     <= w_split_new;
                        err_q       <= 1'b0;
                        if (data_gnt_i) state_q <= w_split_new ? WAIT_RVALID_MIS : WAIT_RVALID;
                        else            state_q <= w_split_new ? WAIT_GNT_MIS : WAIT_GNT;
                    end
                end
                WAIT_GNT_MIS: if (data_gnt_i) state_q <= WAIT_RVALID_MIS;
                WAIT_GNT:     if (data_gnt_i) state_q <= WAIT_RVALID;
                WAIT_RVALID_MIS: begin
                    if (data_rvalid_i) begin
                        rdata_q <= data_rdata_i;
                        err_q   <= data_err_i;
                        state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        state_q <= IDLE;
                        split_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_misaligned_seq.sv
`default_nettype none
// ============================================================================
// tb_lsu_misaligned_seq : scoreboard bench for lsu_misaligned_seq
// Rev 1.0
// ============================================================================
module tb_lsu_misaligned_seq;

    logic        clk;
    logic        rst_ni;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sign_ext_i;
    logic [31:0] lsu_wdata_i;
    logic [31:0] adder_result_ex_i;
    logic        lsu_addr_incr_req_o;
    logic [31:0] lsu_addr_last_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_resp_valid_o;
    logic        load_err_o;
    logic        store_err_o;
    logic        busy_o;

    lsu_misaligned_seq #(.ADDR_W(32)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .lsu_req_i           (lsu_req_i),
        .lsu_we_i            (lsu_we_i),
        .lsu_type_i          (lsu_type_i),
        .lsu_sign_ext_i      (lsu_sign_ext_i),
        .lsu_wdata_i         (lsu_wdata_i),
        .adder_result_ex_i   (adder_result_ex_i),
        .lsu_addr_incr_req_o (lsu_addr_incr_req_o),
        .lsu_addr_last_o     (lsu_addr_last_o),
        .data_req_o          (data_req_o),
        .data_gnt_i          (data_gnt_i),
        .data_rvalid_i       (data_rvalid_i),
        .data_err_i          (data_err_i),
        .data_addr_o         (data_addr_o),
        .data_we_o           (data_we_o),
        .data_be_o           (data_be_o),
        .data_wdata_o        (data_wdata_o),
        .data_rdata_i        (data_rdata_i),
        .lsu_rdata_o         (lsu_rdata_o),
        .lsu_resp_valid_o    (lsu_resp_valid_o),
        .load_err_o          (load_err_o),
        .store_err_o         (store_err_o),
        .busy_o              (busy_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        incr;
        logic [31:0] last;
    } bus_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        lerr;
        logic        serr;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"}, {31'd0, data_req_o}, 32'd0);
        chk({tag, "_incr"}, {31'd0, lsu_addr_incr_req_o}, 32'd0);
        chk({tag, "_last"}, lsu_addr_last_o, 32'd0);
        chk({tag, "_addr"}, data_addr_o, 32'd0);
        chk({tag, "_be"}, {28'd0, data_be_o}, 32'd0);
        chk({tag, "_wdata"}, data_wdata_o, 32'd0);
        chk({tag, "_rdata"}, lsu_rdata_o, 32'd0);
        chk({tag, "_flags"}, {27'd0, data_we_o, lsu_resp_valid_o, load_err_o, store_err_o, busy_o}, 32'd0);
    endtask

    task automatic exp_bus(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                           input logic we, input logic incr, input logic [31:0] last);
        bus_t e;
        e = '{addr: addr, be: be, wdata: wd, we: we, incr: incr, last: last};
        bus_q.push_back(e);
    endtask

    task automatic exp_resp(input logic [31:0] rd, input logic le, input logic se);
        resp_t r;
        r = '{rdata: rd, lerr: le, serr: se};
        resp_q.push_back(r);
    endtask

    // Bus-side monitor: every cycle a request is up it must match the head entry; grant retires it.
    always @(negedge clk) begin
        if (data_req_o) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected_req", {31'd0, data_req_o}, 32'd0);
            end else begin
                bus_t e;
                e = bus_q[0];
                chk("bus_addr", data_addr_o, e.addr);
                chk("bus_be", {28'd0, data_be_o}, {28'd0, e.be});
                chk("bus_wdata", data_wdata_o, e.wdata);
                chk("bus_we", {31'd0, data_we_o}, {31'd0, e.we});
                chk("bus_incr", {31'd0, lsu_addr_incr_req_o}, {31'd0, e.incr});
                if (e.incr) chk("bus_last", lsu_addr_last_o, e.last);
                if (data_gnt_i) void'(bus_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (lsu_resp_valid_o) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", {31'd0, lsu_resp_valid_o}, 32'd0);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk("resp_rdata", lsu_rdata_o, r.rdata);
                chk("resp_load_err", {31'd0, load_err_o}, {31'd0, r.lerr});
                chk("resp_store_err", {31'd0, store_err_o}, {31'd0, r.serr});
            end
        end
    end

    task automatic access(input logic [31:0] addr, input logic we, input logic [1:0] typ,
                          input logic sgn, input logic [31:0] wd, input int dly, input logic split,
                          input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic e1, input logic e2);
        lsu_req_i         = 1'b1;
        lsu_we_i          = we;
        lsu_type_i        = typ;
        lsu_sign_ext_i    = sgn;
        lsu_wdata_i       = wd;
        adder_result_ex_i = addr;
        for (int k = 0; k <= dly; k++) begin
            data_gnt_i = (k == dly);
            @(posedge clk); #1;
            lsu_req_i = 1'b0;
        end
        data_gnt_i = 1'b0;
        if (split) begin
            adder_result_ex_i = addr + 32'd4;
            for (int k = 0; k <= dly; k++) begin
                data_rvalid_i = (k == 0);
                data_rdata_i  = rd1;
                data_err_i    = (k == 0) ? e1 : 1'b0;
                data_gnt_i    = (k == dly);
                @(posedge clk); #1;
            end
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_gnt_i    = 1'b0;
        end
        data_rvalid_i = 1'b1;
        data_rdata_i  = split ? rd2 : rd1;
        data_err_i    = e2;
        @(posedge clk); #1;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = 32'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_ni            = 1'b0;
        lsu_req_i         = 1'b0;
        lsu_we_i          = 1'b0;
        lsu_type_i        = 2'b00;
        lsu_sign_ext_i    = 1'b0;
        lsu_wdata_i       = 32'd0;
        adder_result_ex_i = 32'd0;
        data_gnt_i        = 1'b0;
        data_rvalid_i     = 1'b0;
        data_err_i        = 1'b0;
        data_rdata_i      = 32'd0;
        #12;
        chk_idle("reset");
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Aligned word load
        exp_bus(32'h1000, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h0);
        exp_resp(32'hCAFEF00D, 1'b0, 1'b0);
        access(32'h1000, 1'b0, 2'b00, 1'b0, 32'h0, 0, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);

        // Misaligned word load
        exp_bus(32'h1000, 4'b1110, 32'h0, 1'b0, 1'b0, 32'h0);
        exp_bus(32'h1004, 4'b0001, 32'h0, 1'b0, 1'b1, 32'h1001);
        exp_resp(32'h55443322, 1'b0, 1'b0);
        access(32'h1001, 1'b0, 2'b00, 1'b0, 32'h0, 0, 1'b1, 32'h44332211, 32'h88776655, 1'b0, 1'b0);

        // Misaligned half store, grant delayed 3 cycles per phase
        exp_bus(32'h1000, 4'b1000, 32'hEF0000BE, 1'b1, 1'b0, 32'h0);
        exp_bus(32'h1004, 4'b0001, 32'hEF0000BE, 1'b1, 1'b1, 32'h1003);
        exp_resp(32'h0, 1'b0, 1'b0);
        access(32'h1003, 1'b1, 2'b01, 1'b0, 32'h0000BEEF, 3, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        // Signed and unsigned byte load
        exp_bus(32'h2000, 4'b0100, 32'h0, 1'b0, 1'b0, 32'h0);
        exp_resp(32'hFFFFFF80, 1'b0, 1'b0);
        access(32'h2002, 1'b0, 2'b10, 1'b1, 32'h0, 0, 1'b0, 32'h00800000, 32'h0, 1'b0, 1'b0);
        exp_bus(32'h2000, 4'b0100, 32'h0, 1'b0, 1'b0, 32'h0);
        exp_resp(32'h00000080, 1'b0, 1'b0);
        access(32'h2002, 1'b0, 2'b10, 1'b0, 32'h0, 0, 1'b0, 32'h00800000, 32'h0, 1'b0, 1'b0);

        // Split word load with first-phase error
        exp_bus(32'h3000, 4'b1100, 32'h0, 1'b0, 1'b0, 32'h0);
        exp_bus(32'h3004, 4'b0011, 32'h0, 1'b0, 1'b1, 32'h3002);
        exp_resp(32'h3344AABB, 1'b1, 1'b0);
        access(32'h3002, 1'b0, 2'b00, 1'b0, 32'h0, 0, 1'b1, 32'hAABBCCDD, 32'h11223344, 1'b1, 1'b0);

        // Aligned word store with error and one-cycle grant delay
        exp_bus(32'h4000, 4'b1111, 32'h12345678, 1'b1, 1'b0, 32'h0);
        exp_resp(32'h0, 1'b0, 1'b1);
        access(32'h4000, 1'b1, 2'b00, 1'b0, 32'h12345678, 1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Signed half load at offset 2 (not split)
        exp_bus(32'h5000, 4'b1100, 32'h0, 1'b0, 1'b0, 32'h0);
        exp_resp(32'hFFFF8001, 1'b0, 1'b0);
        access(32'h5002, 1'b0, 2'b01, 1'b1, 32'h0, 0, 1'b0, 32'h80010000, 32'h0, 1'b0, 1'b0);

        // Reset while in WAIT_RVALID_MIS, then a stale rvalid
        exp_bus(32'h1000, 4'b1110, 32'h0, 1'b0, 1'b0, 32'h0);
        lsu_req_i         = 1'b1;
        lsu_we_i          = 1'b0;
        lsu_type_i        = 2'b00;
        lsu_sign_ext_i    = 1'b0;
        adder_result_ex_i = 32'h1001;
        data_gnt_i        = 1'b1;
        @(posedge clk); #1;
        lsu_req_i         = 1'b0;
        data_gnt_i        = 1'b0;
        adder_result_ex_i = 32'h1005;
        #1;
        chk("pre_reset_incr", {31'd0, lsu_addr_incr_req_o}, 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_idle("midreset");
        @(posedge clk); #1;
        rst_ni = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hDEADBEEF;
        @(negedge clk);
        chk("stale_resp", {31'd0, lsu_resp_valid_o}, 32'd0);
        chk("stale_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'd0;
        @(posedge clk); #1;
        chk("stale_after_busy", {31'd0, busy_o}, 32'd0);

        repeat (2) @(posedge clk);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        chk("resp_queue_empty", 32'(resp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
